// File: rtl/gnr_attractor_ctrl.sv
// Sequencing controller for the GNR node array. It loads the nodes, runs Floyd
// cycle detection with tortoise (s0) and hare (s1) step enables, then freezes
// the tortoise and counts hare steps to measure the attractor period.
// Optional build macro GNR_ATTRACTOR_CAPTURE_EN adds the attractor_state output.
module gnr_attractor_ctrl #(
  parameter int unsigned N_NODES   = 8,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned MAX_STEPS = 16'hFFFF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [N_NODES-1:0] init_vec,
  input  logic [N_NODES-1:0] s0_vec,
  input  logic [N_NODES-1:0] s1_vec,
  output logic               reset_nos,
  output logic [N_NODES-1:0] init_state,
  output logic               start_s0,
  output logic               start_s1,
  output logic               busy,
  output logic               done,
  output logic               found,
  output logic               timeout,
  output logic [CNT_W-1:0]   steps,
`ifdef GNR_ATTRACTOR_CAPTURE_EN
  output logic [CNT_W-1:0]   period,
  output logic [N_NODES-1:0] attractor_state
`else
  output logic [CNT_W-1:0]   period
`endif
);

  typedef enum logic [2:0] {
    StIdle,
    StInit,
    StSearch,
    StMeasure,
    StDone
  } state_e;

  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_STEPS);
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  state_e             r_state, w_state_next;
  logic [CNT_W-1:0]   r_steps, w_steps_next;
  logic [CNT_W-1:0]   r_period, w_period_next;
  logic               r_found, w_found_next;
  logic               r_timeout, w_timeout_next;
  logic [N_NODES-1:0] r_init, w_init_next;
  logic [N_NODES-1:0] r_ref, w_ref_next;
  logic               w_match;
  logic               w_pmatch;
  logic               w_accept;
  logic               w_capture;

  // Hare caught tortoise; steps==0 excluded since both still hold init_vec.
  assign w_match  = (s0_vec == s1_vec) && (r_steps != '0);
  // Hare back at the reference point after at least one step.
  assign w_pmatch = (s1_vec == r_ref) && (r_period != '0);

  // Next-state, counters and combinational node strobes.
  always_comb begin
    w_state_next   = r_state;
    w_steps_next   = r_steps;
    w_period_next  = r_period;
    w_found_next   = r_found;
    w_timeout_next = r_timeout;
    w_init_next    = r_init;
    w_ref_next     = r_ref;
    w_accept       = 1'b0;
    w_capture      = 1'b0;
    reset_nos      = 1'b0;
    start_s0       = 1'b0;
    start_s1       = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_accept       = 1'b1;
          w_init_next    = init_vec;
          w_steps_next   = '0;
          w_period_next  = '0;
          w_found_next   = 1'b0;
          w_timeout_next = 1'b0;
          w_state_next   = StInit;
        end
      end
      StInit: begin
        reset_nos    = 1'b1;
        w_state_next = StSearch;
      end
      StSearch: begin
        if (w_match) begin
          w_capture     = 1'b1;
          w_ref_next    = s0_vec;
          w_period_next = '0;
          w_state_next  = StMeasure;
        end else if (r_steps == MaxCnt) begin
          w_timeout_next = 1'b1;
          w_state_next   = StDone;
        end else begin
          start_s0     = 1'b1;
          start_s1     = 1'b1;
          w_steps_next = r_steps + CntOne;
        end
      end
      StMeasure: begin
        if (w_pmatch) begin
          w_found_next = 1'b1;
          w_state_next = StDone;
        end else if (r_period == MaxCnt) begin
          w_timeout_next = 1'b1;
          w_state_next   = StDone;
        end else begin
          start_s1      = 1'b1;
          w_period_next = r_period + CntOne;
        end
      end
      StDone: begin
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  // State, counters, result flags and latched init/reference vectors.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= StIdle;
      r_steps   <= '0;
      r_period  <= '0;
      r_found   <= 1'b0;
      r_timeout <= 1'b0;
      r_init    <= '0;
      r_ref     <= '0;
    end else begin
      r_state   <= w_state_next;
      r_steps   <= w_steps_next;
      r_period  <= w_period_next;
      r_found   <= w_found_next;
      r_timeout <= w_timeout_next;
      r_init    <= w_init_next;
      r_ref     <= w_ref_next;
    end
  end

`ifdef GNR_ATTRACTOR_CAPTURE_EN
  logic [N_NODES-1:0] r_attr;

  // Snapshot of the detected attractor point, cleared on each new run.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_attr <= '0;
    end else if (w_accept) begin
      r_attr <= '0;
    end else if (w_capture) begin
      r_attr <= s0_vec;
    end
  end

  assign attractor_state = r_attr;
`else
  logic w_unused;
  assign w_unused = w_accept ^ w_capture;
`endif

  assign busy       = (r_state == StInit) || (r_state == StSearch) || (r_state == StMeasure);
  assign done       = (r_state == StDone);
  assign found      = r_found;
  assign timeout    = r_timeout;
  assign steps      = r_steps;
  assign period     = r_period;
  assign init_state = r_init;

endmodule

// File: tb/tb_gnr_attractor_ctrl.sv
// Bench for gnr_attractor_ctrl: a behavioural node array driven by a
// programmable next-state table, and a sequence-based Floyd reference.
module tb_gnr_attractor_ctrl;

  localparam int MaxSteps = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] init_vec = '0;
  logic [7:0] s0_vec, s1_vec;
  logic       reset_nos, start_s0, start_s1, busy, done, found, timeout;
  logic [7:0] init_state;
  logic [15:0] steps, period;
`ifdef GNR_ATTRACTOR_CAPTURE_EN
  logic [7:0] attractor_state;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] nxt [256];
  logic       tog;

  gnr_attractor_ctrl #(
    .N_NODES  (8),
    .CNT_W    (16),
    .MAX_STEPS(MaxSteps)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .init_vec  (init_vec),
    .s0_vec    (s0_vec),
    .s1_vec    (s1_vec),
    .reset_nos (reset_nos),
    .init_state(init_state),
    .start_s0  (start_s0),
    .start_s1  (start_s1),
    .busy      (busy),
    .done      (done),
    .found     (found),
    .timeout   (timeout),
    .steps     (steps),
`ifdef GNR_ATTRACTOR_CAPTURE_EN
    .period    (period),
    .attractor_state(attractor_state)
`else
    .period    (period)
`endif
  );

  always #5 clk = ~clk;

  // Node array: hare steps every pulse, tortoise every second pulse.
  always @(posedge clk) begin
    if (reset_nos) begin
      s0_vec <= init_state;
      s1_vec <= init_state;
      tog    <= 1'b0;
    end else begin
      if (start_s1) s1_vec <= nxt[s1_vec];
      if (start_s0) begin
        if (tog) s0_vec <= nxt[s0_vec];
        tog <= ~tog;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: x[i] = f^i(init); tortoise after i pulses sits at x[i/2].
  task automatic expect_run(input logic [7:0] iv, output int k, output int p,
                            output bit fnd, output bit tmo, output logic [7:0] rf);
    logic [7:0] x [128];
    x[0] = iv;
    for (int i = 1; i < 128; i++) x[i] = nxt[x[i-1]];
    k = 0; p = 0; fnd = 0; tmo = 0; rf = '0;
    for (int i = 1; i <= MaxSteps; i++) begin
      if (x[i] == x[i/2]) begin
        k = i;
        break;
      end
    end
    if (k == 0) begin
      k   = MaxSteps;
      tmo = 1;
    end else begin
      rf = x[k];
      for (int j = 1; j <= MaxSteps; j++) begin
        if (x[k+j] == rf) begin
          p = j;
          break;
        end
      end
      if (p == 0) begin
        p   = MaxSteps;
        tmo = 1;
      end else begin
        fnd = 1;
      end
    end
  endtask

  // One complete run from a negedge; poke re-pulses start while busy.
  task automatic run(input string tag, input logic [7:0] iv, input bit poke);
    int k, p, n_rn, n_s0, n_s1, done_idx, exp_idx;
    bit fnd, tmo;
    logic [7:0] rf;
    expect_run(iv, k, p, fnd, tmo, rf);
    n_rn = 0; n_s0 = 0; n_s1 = 0; done_idx = -1;
    start    = 1'b1;
    init_vec = iv;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 200; c++) begin
      n_rn += int'(reset_nos);
      n_s0 += int'(start_s0);
      n_s1 += int'(start_s1);
      if (done) begin
        done_idx = c;
        break;
      end
      if (poke && c == 3) begin
        start    = 1'b1;
        init_vec = ~iv;
      end else if (poke && c == 4) begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    exp_idx = (tmo && !fnd && p == 0) ? MaxSteps + 2 : k + p + 3;
    check({tag, " done_latency"}, done_idx, exp_idx);
    check({tag, " steps"}, 32'(steps), k);
    check({tag, " period"}, 32'(period), p);
    check({tag, " found"}, 32'(found), 32'(fnd));
    check({tag, " timeout"}, 32'(timeout), 32'(tmo));
    check({tag, " busy_at_done"}, 32'(busy), 0);
    check({tag, " init_state"}, 32'(init_state), 32'(iv));
    check({tag, " reset_nos_cycles"}, n_rn, 1);
    check({tag, " s0_pulses"}, n_s0, k);
    check({tag, " s1_pulses"}, n_s1, k + p);
`ifdef GNR_ATTRACTOR_CAPTURE_EN
    if (fnd) check({tag, " attractor_state"}, 32'(attractor_state), 32'(rf));
`endif
    @(negedge clk);
    check({tag, " done_one_cycle"}, 32'(done), 0);
    check({tag, " steps_hold"}, 32'(steps), k);
    check({tag, " found_hold"}, 32'(found), 32'(fnd));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) nxt[i] = 8'(i);
    @(negedge clk);
    check("reset outputs", {24'd0, reset_nos, start_s0, start_s1, busy, done, found,
                            timeout, 1'b0}, 0);
    check("reset counters", {steps, period}, 0);
    check("reset init_state", 32'(init_state), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Fixed point: every state maps to itself.
    run("fixed", 8'hA5, 1'b0);

    // 3-bit ring counter in the low bits.
    for (int i = 0; i < 256; i++) nxt[i] = {i[7:3], 3'(i[2:0] + 3'd1)};
    run("ring8", 8'h00, 1'b0);

    // Two-state transient into a 3-cycle.
    for (int i = 0; i < 256; i++) nxt[i] = 8'(i);
    nxt[8'h10] = 8'h20; nxt[8'h20] = 8'h30;
    nxt[8'h30] = 8'h40; nxt[8'h40] = 8'h50; nxt[8'h50] = 8'h30;
    run("tail_cycle3", 8'h10, 1'b0);

    // 256-long cycle: search budget runs out.
    for (int i = 0; i < 256; i++) nxt[i] = 8'(i + 1);
    run("search_timeout", 8'h07, 1'b0);

    // Fixed point again clears the timeout; start pulsed mid-run is ignored.
    for (int i = 0; i < 256; i++) nxt[i] = 8'(i);
    run("after_timeout", 8'h3C, 1'b1);
    nxt[8'h61] = 8'h62; nxt[8'h62] = 8'h61;
    run("busy_start", 8'h61, 1'b1);

    // Random functional graphs.
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 256; i++) nxt[i] = 8'($urandom_range(0, 255));
      run($sformatf("random%0d", r), 8'($urandom_range(0, 255)), 1'b0);
    end

    // Asynchronous reset in the middle of SEARCH.
    for (int i = 0; i < 256; i++) nxt[i] = 8'(i + 1);
    start    = 1'b1;
    init_vec = 8'h5A;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_reset busy", 32'(busy), 1);
    #2 rst = 1'b0;
    #1;
    check("midrun reset outputs", {24'd0, reset_nos, start_s0, start_s1, busy, done, found,
                                   timeout, 1'b0}, 0);
    check("midrun reset counters", {steps, period}, 0);
    check("midrun reset init_state", 32'(init_state), 0);
`ifdef GNR_ATTRACTOR_CAPTURE_EN
    check("midrun reset attractor_state", 32'(attractor_state), 0);
`endif
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 256; i++) nxt[i] = 8'(i);
    nxt[8'h11] = 8'h22; nxt[8'h22] = 8'h33; nxt[8'h33] = 8'h22;
    run("after_reset", 8'h11, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
